// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: pops byte commands from the UART RX FIFO, drives register-file strobes, returns read data via TX FIFO.
// Define UART_CMD_CTRL_ACK_EN to also emit ACK (8'hA5) / NAK (8'hEE) bytes for writes, malformed headers and timeouts.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_fifo_e,
    output logic       o_rx_rd,
    output logic [7:0] o_tx_data,
    output logic       o_tx_wr,
    input  logic       i_tx_fifo_f,
    output logic [2:0] o_rwaddr,
    output logic [7:0] o_write_data,
    output logic       o_wr_req,
    output logic       o_rd_req,
    input  logic [7:0] i_read_data,
    output logic       o_busy,
    output logic       o_timeout,
    output logic [7:0] o_err_cnt
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef UART_CMD_CTRL_ACK_EN
    localparam logic [7:0]       ACK_BYTE = 8'hA5;
    localparam logic [7:0]       NAK_BYTE = 8'hEE;
`endif

    typedef enum logic [2:0] {
        IDLE,
        GET_DATA,
        WRITE,
        READ_REQ,
        READ_WAIT,
        TX_PUSH
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       txdata_q;
    logic [7:0]       errcnt_q;
    logic [7:0]       errcnt_d;

    logic hdrMalformed;
    logic rxPop;
    logic txPush;
    logic cntExpired;

    assign hdrMalformed = |i_rx_data[6:3];
    assign errcnt_d     = (errcnt_q == 8'hFF) ? errcnt_q : errcnt_q + 8'd1;

    // Pops and pushes are gated by reset so a reset cycle never consumes or emits a byte.
    assign rxPop      = !i_rst && !i_rx_fifo_e && ((state_q == IDLE) || (state_q == GET_DATA));
    assign txPush     = !i_rst && !i_tx_fifo_f && (state_q == TX_PUSH);
    assign cntExpired = !i_rst && i_rx_fifo_e && (state_q == GET_DATA) && (cnt_q == CNT_LAST);

    assign o_rx_rd      = rxPop;
    assign o_tx_wr      = txPush;
    assign o_tx_data    = txdata_q;
    assign o_rwaddr     = addr_q;
    assign o_write_data = wdata_q;
    assign o_wr_req     = (state_q == WRITE);
    assign o_rd_req     = (state_q == READ_REQ);
    assign o_busy       = (state_q != IDLE);
    assign o_timeout    = cntExpired;
    assign o_err_cnt    = errcnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            txdata_q <= '0;
            errcnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!i_rx_fifo_e) begin
                        if (hdrMalformed) begin
                            errcnt_q <= errcnt_d;
`ifdef UART_CMD_CTRL_ACK_EN
                            txdata_q <= NAK_BYTE;
                            state_q  <= TX_PUSH;
`endif
                        end else begin
                            addr_q <= i_rx_data[2:0];
                            if (i_rx_data[7]) begin
                                cnt_q   <= '0;
                                state_q <= GET_DATA;
                            end else begin
                                state_q <= READ_REQ;
                            end
                        end
                    end
                end

                // A byte arriving on the expiry cycle takes priority over the timeout.
                GET_DATA: begin
                    if (!i_rx_fifo_e) begin
                        wdata_q <= i_rx_data;
                        state_q <= WRITE;
                    end else if (cnt_q == CNT_LAST) begin
`ifdef UART_CMD_CTRL_ACK_EN
                        txdata_q <= NAK_BYTE;
                        state_q  <= TX_PUSH;
`else
                        state_q  <= IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                WRITE: begin
`ifdef UART_CMD_CTRL_ACK_EN
                    txdata_q <= ACK_BYTE;
                    state_q  <= TX_PUSH;
`else
                    state_q  <= IDLE;
`endif
                end

                READ_REQ: begin
                    state_q <= READ_WAIT;
                end

                READ_WAIT: begin
                    txdata_q <= i_read_data;
                    state_q  <= TX_PUSH;
                end

                TX_PUSH: begin
                    if (!i_tx_fifo_f) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: scoreboard bench for uart_cmd_ctrl with modelled RX FIFO, TX FIFO and register file.
// Expected TX bytes, writes and reads are queued when commands are queued and popped when the DUT acts.
module tb_uart_cmd_ctrl;

    localparam int unsigned TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_rx_data;
    logic       i_rx_fifo_e;
    logic       o_rx_rd;
    logic [7:0] o_tx_data;
    logic       o_tx_wr;
    logic       i_tx_fifo_f;
    logic [2:0] o_rwaddr;
    logic [7:0] o_write_data;
    logic       o_wr_req;
    logic       o_rd_req;
    logic [7:0] i_read_data;
    logic       o_busy;
    logic       o_timeout;
    logic [7:0] o_err_cnt;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_fifo_e (i_rx_fifo_e),
        .o_rx_rd     (o_rx_rd),
        .o_tx_data   (o_tx_data),
        .o_tx_wr     (o_tx_wr),
        .i_tx_fifo_f (i_tx_fifo_f),
        .o_rwaddr    (o_rwaddr),
        .o_write_data(o_write_data),
        .o_wr_req    (o_wr_req),
        .o_rd_req    (o_rd_req),
        .i_read_data (i_read_data),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout),
        .o_err_cnt   (o_err_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0]  rxQ[$];
    logic [7:0]  txExp[$];
    logic [10:0] wrExp[$];
    logic [7:0]  regFile[8];
    logic [7:0]  modelRegs[8];

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   lastPopCycle = 0;
    int   rdCycle = 0;
    int   rdExpCount = 0;
    int   timeoutCount = 0;
    int   fullDropCycle = 0;
    bit   rdNext = 1'b0;
    bit   readTxPending = 1'b0;
    bit   stallSeen = 1'b0;
    bit   stallTest = 1'b0;
    logic [2:0] rdAddr = 3'd0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic updateRx();
        i_rx_fifo_e = (rxQ.size() == 0);
        i_rx_data   = (rxQ.size() != 0) ? rxQ[0] : 8'h00;
    endtask

    task automatic rxPush(input logic [7:0] b);
        rxQ.push_back(b);
        updateRx();
    endtask

    task automatic sendWrite(input logic [2:0] addr, input logic [7:0] data);
        rxPush({1'b1, 4'b0000, addr});
        rxPush(data);
        modelRegs[addr] = data;
        wrExp.push_back({addr, data});
`ifdef UART_CMD_CTRL_ACK_EN
        txExp.push_back(8'hA5);
`endif
    endtask

    task automatic sendRead(input logic [2:0] addr);
        rxPush({1'b0, 4'b0000, addr});
        rdExpCount++;
        txExp.push_back(modelRegs[addr]);
    endtask

    // One clock: observe outputs at the falling edge, then apply FIFO/register-file effects after the rising edge.
    task automatic applyStimulus();
        bit popNow;
        popNow = 1'b0;
        rdNext = 1'b0;
        @(negedge clk);
        cyc++;
        checkOutput("rxRdWhenEmpty", {31'b0, o_rx_rd & i_rx_fifo_e}, 32'd0);
        checkOutput("txWrWhenFull", {31'b0, o_tx_wr & i_tx_fifo_f}, 32'd0);
        checkOutput("wrRdOverlap", {31'b0, o_wr_req & o_rd_req}, 32'd0);
        if (readTxPending && i_tx_fifo_f) stallSeen = 1'b1;
        if (o_rx_rd) begin
            popNow = 1'b1;
            lastPopCycle = cyc;
        end
        if (o_rd_req) begin
            checkOutput("rdLatency", cyc - lastPopCycle, 32'd1);
            if (rdExpCount == 0) begin
                checkOutput("rdUnexpected", 32'd1, 32'd0);
            end else begin
                rdExpCount--;
            end
            rdAddr = o_rwaddr;
            rdNext = 1'b1;
            rdCycle = cyc;
            readTxPending = 1'b1;
            stallSeen = 1'b0;
        end
        if (o_wr_req) begin
            checkOutput("wrLatency", cyc - lastPopCycle, 32'd1);
            if (wrExp.size() == 0) begin
                checkOutput("wrUnexpected", {21'b0, o_rwaddr, o_write_data}, 32'd0);
            end else begin
                checkOutput("wrAddrData", {21'b0, o_rwaddr, o_write_data}, {21'b0, wrExp.pop_front()});
            end
            regFile[o_rwaddr] = o_write_data;
        end
        if (o_tx_wr) begin
            if (txExp.size() == 0) begin
                checkOutput("txUnexpected", {24'b0, o_tx_data}, 32'd0);
            end else begin
                checkOutput("txByte", {24'b0, o_tx_data}, {24'b0, txExp.pop_front()});
            end
            if (readTxPending) begin
                if (!stallSeen) checkOutput("txLatency", cyc - rdCycle, 32'd2);
                readTxPending = 1'b0;
            end
            if (stallTest) begin
                checkOutput("pushOnFullDrop", cyc, fullDropCycle);
                stallTest = 1'b0;
            end
        end
        if (o_timeout) begin
            timeoutCount++;
            checkOutput("timeoutLatency", cyc - lastPopCycle, TIMEOUT);
        end
        @(posedge clk);
        #1;
        if (popNow) void'(rxQ.pop_front());
        i_read_data = rdNext ? regFile[rdAddr] : 8'hC3;
        updateRx();
    endtask

    task automatic runUntilIdle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (rxQ.size() == 0 && !o_busy && txExp.size() == 0 && wrExp.size() == 0 && rdExpCount == 0)
                done = 1'b1;
            else
                applyStimulus();
        end
        if (!done) checkOutput("drainBudget", 32'd1, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            regFile[i]   = 8'h10 + 8'(i);
            modelRegs[i] = 8'h10 + 8'(i);
        end
        regFile[4] = 8'h5C;  modelRegs[4] = 8'h5C;
        regFile[5] = 8'h3A;  modelRegs[5] = 8'h3A;
        i_rst       = 1'b1;
        i_tx_fifo_f = 1'b0;
        i_read_data = 8'hC3;
        updateRx();
        repeat (3) applyStimulus();
        checkOutput("rstBusy", {31'b0, o_busy}, 32'd0);
        checkOutput("rstErrCnt", {24'b0, o_err_cnt}, 32'd0);
        checkOutput("rstAddrData", {21'b0, o_rwaddr, o_write_data}, 32'd0);
        checkOutput("rstTxData", {24'b0, o_tx_data}, 32'd0);
        i_rst = 1'b0;

        sendWrite(3'd0, 8'h03);
        runUntilIdle(50);
        sendRead(3'd4);
        runUntilIdle(50);
        sendWrite(3'd7, 8'hB2);
        sendRead(3'd7);
        runUntilIdle(50);

        // Read response held off by a full TX FIFO.
        i_tx_fifo_f = 1'b1;
        sendRead(3'd4);
        repeat (12) applyStimulus();
        checkOutput("stallBusy", {31'b0, o_busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("txHoldWhileFull", {24'b0, o_tx_data}, 32'h5C);
            applyStimulus();
        end
        i_tx_fifo_f = 1'b0;
        stallTest = 1'b1;
        fullDropCycle = cyc + 1;
        runUntilIdle(20);
        checkOutput("stallPushSeen", {31'b0, stallTest}, 32'd0);

        // Write header with no data byte: must time out, then the next byte is a fresh header.
        rxPush(8'h82);
`ifdef UART_CMD_CTRL_ACK_EN
        txExp.push_back(8'hEE);
`endif
        repeat (TIMEOUT + 8) applyStimulus();
        checkOutput("timeoutCount", timeoutCount, 32'd1);
        checkOutput("timeoutIdle", {31'b0, o_busy}, 32'd0);
        sendRead(3'd5);
        runUntilIdle(50);

        // Malformed headers: counted, saturating, never touching the register file.
        for (int i = 0; i < 10; i++) begin
            rxPush(8'h48);
`ifdef UART_CMD_CTRL_ACK_EN
            txExp.push_back(8'hEE);
`endif
        end
        runUntilIdle(100);
        checkOutput("errCnt10", {24'b0, o_err_cnt}, 32'd10);
        for (int i = 0; i < 290; i++) begin
            rxPush(8'h48);
`ifdef UART_CMD_CTRL_ACK_EN
            txExp.push_back(8'hEE);
`endif
        end
        runUntilIdle(1500);
        checkOutput("errCntSat", {24'b0, o_err_cnt}, 32'hFF);

        // Reset while waiting for write data discards the partial command.
        rxPush(8'h81);
        repeat (4) applyStimulus();
        checkOutput("midBusy", {31'b0, o_busy}, 32'd1);
        i_rst = 1'b1;
        applyStimulus();
        checkOutput("rstMidBusy", {31'b0, o_busy}, 32'd0);
        checkOutput("rstMidErrCnt", {24'b0, o_err_cnt}, 32'd0);
        checkOutput("rstMidStrobes", {28'b0, o_wr_req, o_rd_req, o_tx_wr, o_timeout}, 32'd0);
        checkOutput("rstMidAddr", {29'b0, o_rwaddr}, 32'd0);
        i_rst = 1'b0;
        applyStimulus();
        sendWrite(3'd3, 8'h77);
        sendRead(3'd3);
        runUntilIdle(50);

        checkOutput("txExpLeft", txExp.size(), 32'd0);
        checkOutput("wrExpLeft", wrExp.size(), 32'd0);
        checkOutput("rdExpLeft", rdExpCount, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
